// File: rtl/rv32i_fetch_stage_if.sv
// Fetch-stage boundary: instruction-memory port plus decode-side handshake.
// master = fetch stage, slave = decode / memory environment.
interface rv32i_fetch_stage_if;
  logic        stall;
  logic        jump_en_in;
  logic [31:0] jump_addr_in;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;
  logic [31:0] iw_out;
  logic [31:0] pc_out;
  logic        jump_en_out;
  logic        halted;
  logic        misalign;

  modport master (
    input  stall, jump_en_in, jump_addr_in, imem_data,
    output imem_addr, imem_rd_en, iw_out, pc_out, jump_en_out, halted, misalign
  );

  modport slave (
    output stall, jump_en_in, jump_addr_in, imem_data,
    input  imem_addr, imem_rd_en, iw_out, pc_out, jump_en_out, halted, misalign
  );
endinterface

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction fetch: owns the PC, drives a 1-cycle-latency imem,
// absorbs stalls with a hold register, takes redirects and halts on EBREAK.
//
// state | meaning
// FILL  | no valid word returning from imem (after reset or redirect)
// RUN   | imem_data carries the word at pc_f2
// HALT  | EBREAK retired; fetch stopped until reset
module rv32i_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_IW    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_IW = 32'h0010_0073
) (
  input  logic                clk,
  input  logic                reset,
  rv32i_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {FILL, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pc_f2;
  logic        valid_f2;
  logic [31:0] hold_iw;
  logic        hold_valid;
  logic        jump_en_q;
  logic        halted_q;
  logic        misalign_q;
  logic [31:0] iw_cur;

  always_comb begin
    iw_cur = NOP_IW;
    if (halted_q)        iw_cur = NOP_IW;
    else if (hold_valid) iw_cur = hold_iw;
    else if (valid_f2)   iw_cur = bus.imem_data;
  end

  assign bus.iw_out      = iw_cur;
  assign bus.pc_out      = pc_f2;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_rd_en  = ~halted_q;
  assign bus.jump_en_out = jump_en_q;
  assign bus.halted      = halted_q;
  assign bus.misalign    = misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      pc_q       <= RESET_PC;
      pc_f2      <= RESET_PC;
      valid_f2   <= 1'b0;
      hold_iw    <= NOP_IW;
      hold_valid <= 1'b0;
      jump_en_q  <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else if (state != HALT && bus.jump_en_in) begin
      // redirect wins over stall; the target is force-aligned either way
      pc_q       <= {bus.jump_addr_in[31:2], 2'b00};
      valid_f2   <= 1'b0;
      hold_valid <= 1'b0;
      jump_en_q  <= 1'b1;
      state      <= FILL;
      if (bus.jump_addr_in[1:0] != 2'b00) misalign_q <= 1'b1;
    end else begin
      jump_en_q <= 1'b0;
      case (state)
        HALT: ;
        default: begin
          if (state == RUN && iw_cur == EBREAK_IW && !bus.stall) begin
            halted_q   <= 1'b1;
            hold_valid <= 1'b0;
            valid_f2   <= 1'b0;
            state      <= HALT;
          end else if (bus.stall) begin
            // memory keeps re-reading pc_q, so the word on show must be captured
            if (!hold_valid) begin
              hold_iw    <= iw_cur;
              hold_valid <= 1'b1;
            end
          end else begin
            hold_valid <= 1'b0;
            pc_f2      <= pc_q;
            valid_f2   <= 1'b1;
            pc_q       <= pc_q + 32'd4;
            state      <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rv32i_fetch_stage.md
Name: rv32i_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents instruction word and PC to decode, and accepts redirects (JAL/JALR/taken branch) from decode.
- Handles pipeline stalls with an internal hold register and stops fetching on EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetched instruction.
- NOP_IW, 32'h0000_0013, word issued for bubbles (addi x0,x0,0).
- EBREAK_IW, 32'h0010_0073, word that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard-unit hold request; freezes PC and outputs.
- jump_en_in  in  1  redirect request from decode.
- jump_addr_in  in  32  redirect target from decode.
- imem_addr  out  32  instruction memory address (= pc_q).
- imem_rd_en  out  1  instruction memory read enable.
- imem_data  in  32  memory word; valid the cycle after imem_addr/imem_rd_en are sampled.
- iw_out  out  32  instruction word to decode.
- pc_out  out  32  PC of iw_out.
- jump_en_out  out  1  one-cycle redirect echo to decode; suppresses a second redirect on the bubble.
- halted  out  1  fetch halted on EBREAK.
- misalign  out  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Registers:
  - pc_q: fetch address.
  - pc_f2 / valid_f2: tag of the word returning on imem_data.
  - hold_iw / hold_valid: stall capture.
  - state.
- Outputs:
  - iw_out = halted ? NOP_IW : hold_valid ? hold_iw : valid_f2 ? imem_data : NOP_IW.
  - pc_out = pc_f2.
  - imem_addr = pc_q.
  - imem_rd_en = ~halted.
- Reset values:
  - pc_q = pc_f2 = RESET_PC.
  - valid_f2 = 0; hold_valid = 0; jump_en_out = 0; halted = 0; misalign = 0; state = FILL.
  - Resulting outputs: iw_out = NOP_IW, pc_out = RESET_PC, imem_addr = RESET_PC, imem_rd_en = 1.
- States:
  - FILL: valid_f2 = 0; entered on reset and on redirect.
  - RUN: valid_f2 = 1.
  - HALT: terminal; exits only via reset.
- Event priority each cycle: reset > redirect > halt detect > stall > normal advance.
- Normal advance (RUN or FILL, no stall):
  - pc_f2 <= pc_q; valid_f2 <= 1; pc_q <= pc_q + 4.
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC wraps to 0 with no flag.
  - FILL -> RUN.
- Latency:
  - First instruction reaches iw_out 2 cycles after reset deasserts: cycle 1 NOP, cycle 2 mem[RESET_PC].
  - Steady state: one instruction per cycle.
- Redirect (jump_en_in = 1, not in HALT):
  - pc_q <= {jump_addr_in[31:2], 2'b00}; valid_f2 <= 0; hold_valid <= 0; jump_en_out <= 1; state <= FILL.
  - Accepted even when stall = 1; stall is ignored that cycle.
  - Cycle N+1: iw_out = NOP_IW, pc_out unchanged, jump_en_out = 1.
  - Cycle N+2: iw_out = mem[target], pc_out = target, jump_en_out = 0.
  - If jump_addr_in[1:0] != 0: misalign <= 1 (sticky until reset); target is still force-aligned.
  - Otherwise jump_en_out <= 0 every cycle.
- Stall (stall = 1, no redirect):
  - pc_q, pc_f2 and valid_f2 hold.
  - First stall cycle: hold_iw <= current iw_out, hold_valid <= 1.
  - While hold_valid = 1, iw_out/pc_out stay fixed; memory keeps re-reading pc_q.
  - On release, hold_valid <= 0 and the normal advance occurs that same edge; no instruction is lost or duplicated.
  - Stall in FILL: NOP_IW held; pc_q held.
- Halt detect (RUN, iw_out == EBREAK_IW, not stalled, no redirect):
  - Next cycle: halted = 1, state = HALT, imem_rd_en = 0, iw_out = NOP_IW; pc_q frozen.
  - The EBREAK word itself is presented for exactly one cycle.
  - stall and jump_en_in are ignored in HALT.
- Reset mid-stall, mid-redirect or in HALT: all state returns to reset values the next cycle.

Test Plan:
- Reset release, mem[0..3] = addi words -> cycle 1 iw_out = 0x13/pc 0; cycles 2..5 pc_out = 0,4,8,C with matching words; imem_addr leads pc_out by 4.
- jump_en_in = 1, jump_addr_in = 0x40 while pc_out = 0x8 -> next cycle iw_out = 0x13, jump_en_out = 1; following cycle pc_out = 0x40, iw_out = mem[0x40], jump_en_out = 0.
- stall held 3 cycles while pc_out = 0xC -> iw_out/pc_out constant for 3 cycles; after release pc_out = 0x10, then 0x14, with no gap or repeat.
- stall = 1 and jump_en_in = 1, jump_addr_in = 0x22 in the same cycle -> redirect taken to 0x20, misalign = 1 and stays 1; hold cleared.
- mem[0x8] = 0x00100073 -> iw_out = EBREAK for one cycle, then halted = 1, imem_rd_en = 0, iw_out = 0x13; a later jump_en_in is ignored; reset restarts at RESET_PC.
- Redirect to 0xFFFFFFF8 -> pc_out sequence FFFFFFF8, FFFFFFFC, 00000000; no flags raised.
